// File: rtl/usb_rx_packet_decoder_pkg.sv
// Shared USB receive definitions: PID codes, decoder state encoding and payload limit.
// Also holds the PID self-check helper used by the decoder.
package usb_pkg;

  localparam logic [3:0] PID_OUT   = 4'h1;
  localparam logic [3:0] PID_IN    = 4'h9;
  localparam logic [3:0] PID_SETUP = 4'hD;
  localparam logic [3:0] PID_DATA0 = 4'h3;
  localparam logic [3:0] PID_DATA1 = 4'hB;
  localparam logic [3:0] PID_ACK   = 4'h2;
  localparam logic [3:0] PID_NAK   = 4'hA;
  localparam logic [3:0] PID_STALL = 4'hE;

  localparam int MAX_PAYLOAD = 64;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PID,
    ST_TOKEN1,
    ST_TOKEN2,
    ST_HSHAKE,
    ST_DATA,
    ST_FLUSH,
    ST_FINISH
  } dec_state_t;

  // The upper nibble of a PID byte is the ones-complement of the lower nibble.
  function automatic logic pid_check_ok(input logic [7:0] pid_byte);
    return pid_byte[7:4] == ~pid_byte[3:0];
  endfunction

endpackage

// File: rtl/usb_rx_packet_decoder_crc_strip_buffer.sv
// Two-entry delay line that withholds the trailing CRC16 bytes of a data packet.
// A byte is released only once two newer bytes have arrived behind it.
module crc_strip_buffer
  import usb_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic              flush,
  input  logic [DATA_W-1:0] byte_in,
  output logic              out_valid,
  output logic [DATA_W-1:0] byte_out,
  output logic              full
);

  logic [1:0]        fill;
  logic [DATA_W-1:0] hold_p0;
  logic [DATA_W-1:0] hold_p1;

  assign full = (fill == 2'd2);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fill      <= 2'd0;
      out_valid <= 1'b0;
      byte_out  <= '0;
    end else begin
      out_valid <= 1'b0;
      if (flush) begin
        fill <= 2'd0;
      end else if (push) begin
        if (fill == 2'd2) begin
          byte_out  <= hold_p0;
          out_valid <= 1'b1;
        end else begin
          fill <= fill + 2'd1;
        end
      end
    end
  end

  // Storage stage: held bytes carry no reset, the fill level qualifies them.
  always_ff @(posedge clk) begin
    if (push && !flush) begin
      if (fill == 2'd2) begin
        hold_p0 <= hold_p1;
        hold_p1 <= byte_in;
      end else if (fill == 2'd1) begin
        hold_p1 <= byte_in;
      end else begin
        hold_p0 <= byte_in;
      end
    end
  end

endmodule

// File: rtl/usb_rx_packet_decoder.sv
// USB receive packet decoder: pops bytes from the RX FIFO, decodes PID, token and
// data packets, strips CRC16 from payloads and reports completion or error.
module usb_rx_packet_decoder
  import usb_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] r_data,
  input  logic       empty,
  input  logic       rcving,
  input  logic       r_error,
  output logic       r_enable,
  output logic [3:0] pid,
  output logic [6:0] token_addr,
  output logic [3:0] token_endp,
  output logic [7:0] rx_data,
  output logic       rx_data_valid,
  output logic [6:0] byte_count,
  output logic       pkt_done,
  output logic       pkt_error
);

  dec_state_t state;
  dec_state_t state_nxt;

  logic eop;
  logic buf_push;
  logic buf_flush;
  logic buf_full;
  logic endp0;
  logic tok2_taken;
  logic err_flag;

  assign eop = !rcving && empty;

  crc_strip_buffer #(
    .DATA_W(8)
  ) u_crc_strip (
    .clk      (clk),
    .rst      (rst),
    .push     (buf_push),
    .flush    (buf_flush),
    .byte_in  (r_data),
    .out_valid(rx_data_valid),
    .byte_out (rx_data),
    .full     (buf_full)
  );

  always_comb begin
    state_nxt = state;
    r_enable  = 1'b0;
    buf_push  = 1'b0;
    buf_flush = 1'b0;
    case (state)
      ST_IDLE: begin
        if (!empty) state_nxt = ST_PID;
      end
      ST_PID: begin
        r_enable = !empty;
        if (!empty) begin
          if (!pid_check_ok(r_data)) begin
            state_nxt = ST_FLUSH;
          end else begin
            case (r_data[3:0])
              PID_OUT, PID_IN, PID_SETUP: state_nxt = ST_TOKEN1;
              PID_DATA0, PID_DATA1:       state_nxt = ST_DATA;
              PID_ACK, PID_NAK, PID_STALL: state_nxt = ST_HSHAKE;
              default:                    state_nxt = ST_FLUSH;
            endcase
          end
        end
      end
      ST_TOKEN1: begin
        r_enable = !empty;
        if (!empty)   state_nxt = ST_TOKEN2;
        else if (eop) state_nxt = ST_FLUSH;
      end
      ST_TOKEN2: begin
        // Stays here after the second token byte to catch a surplus byte before EOP.
        r_enable = !empty;
        if (!empty)   state_nxt = tok2_taken ? ST_FLUSH : ST_TOKEN2;
        else if (eop) state_nxt = tok2_taken ? ST_FINISH : ST_FLUSH;
      end
      ST_HSHAKE: begin
        r_enable = !empty;
        if (!empty)   state_nxt = ST_FLUSH;
        else if (eop) state_nxt = ST_FINISH;
      end
      ST_DATA: begin
        r_enable = !empty;
        if (!empty) begin
          if (buf_full && (byte_count == 7'(MAX_PAYLOAD))) state_nxt = ST_FLUSH;
          else                                             buf_push  = 1'b1;
        end else if (eop) begin
          state_nxt = buf_full ? ST_FINISH : ST_FLUSH;
        end
      end
      ST_FLUSH: begin
        r_enable = !empty;
        if (eop) state_nxt = ST_FINISH;
      end
      ST_FINISH: begin
        state_nxt = ST_IDLE;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase

    if (r_error && (state != ST_IDLE)) begin
      state_nxt = ST_FLUSH;
      buf_push  = 1'b0;
    end

    // Leaving DATA discards whatever is still held, i.e. the CRC16 bytes.
    buf_flush = (state_nxt != ST_DATA);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      pid        <= 4'h0;
      token_addr <= 7'h00;
      token_endp <= 4'h0;
      endp0      <= 1'b0;
      byte_count <= 7'd0;
      tok2_taken <= 1'b0;
      err_flag   <= 1'b0;
    end else begin
      state <= state_nxt;

      if ((state == ST_IDLE) && (state_nxt == ST_PID)) begin
        byte_count <= 7'd0;
        tok2_taken <= 1'b0;
      end

      if ((state == ST_PID) && r_enable) pid <= r_data[3:0];

      if ((state == ST_TOKEN1) && (state_nxt == ST_TOKEN2)) begin
        token_addr <= r_data[6:0];
        endp0      <= r_data[7];
      end

      if ((state == ST_TOKEN2) && (state_nxt == ST_TOKEN2) && r_enable && !tok2_taken) begin
        token_endp <= {r_data[2:0], endp0};
        tok2_taken <= 1'b1;
      end

      if (buf_push && buf_full) byte_count <= byte_count + 7'd1;

      if (state_nxt == ST_FINISH) err_flag <= (state == ST_FLUSH);
    end
  end

  assign pkt_done  = (state == ST_FINISH) && !err_flag;
  assign pkt_error = (state == ST_FINISH) && err_flag;

endmodule

// File: tb/tb_usb_rx_packet_decoder.sv
// Directed bench for usb_rx_packet_decoder with a small RX FIFO model and strobe monitor.
module tb_usb_rx_packet_decoder;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] r_data;
  logic       empty;
  logic       rcving;
  logic       r_error;
  logic       r_enable;
  logic [3:0] pid;
  logic [6:0] token_addr;
  logic [3:0] token_endp;
  logic [7:0] rx_data;
  logic       rx_data_valid;
  logic [6:0] byte_count;
  logic       pkt_done;
  logic       pkt_error;

  usb_rx_packet_decoder dut (
    .clk          (clk),
    .rst          (rst),
    .r_data       (r_data),
    .empty        (empty),
    .rcving       (rcving),
    .r_error      (r_error),
    .r_enable     (r_enable),
    .pid          (pid),
    .token_addr   (token_addr),
    .token_endp   (token_endp),
    .rx_data      (rx_data),
    .rx_data_valid(rx_data_valid),
    .byte_count   (byte_count),
    .pkt_done     (pkt_done),
    .pkt_error    (pkt_error)
  );

  always #5 clk = ~clk;

  // FIFO model: bench writes mem/tail, the pop pointer follows r_enable.
  logic [7:0] mem [0:255];
  logic [7:0] head = 8'd0;
  logic [7:0] tail = 8'd0;
  assign r_data = mem[head];
  assign empty  = (head == tail);
  always @(posedge clk) if (r_enable) head <= head + 8'd1;

  // Strobe monitor.
  logic [7:0] rx_log [0:255];
  int n_valid = 0;
  int n_done = 0;
  int n_err = 0;
  int n_overlap = 0;
  always @(negedge clk) begin
    if (rx_data_valid === 1'b1) begin
      rx_log[n_valid % 256] <= rx_data;
      n_valid <= n_valid + 1;
    end
    if (pkt_done === 1'b1) n_done <= n_done + 1;
    if (pkt_error === 1'b1) n_err <= n_err + 1;
    if ((int'(rx_data_valid === 1'b1) + int'(pkt_done === 1'b1) + int'(pkt_error === 1'b1)) > 1)
      n_overlap <= n_overlap + 1;
  end

  int compared = 0;
  int mismatched = 0;
  int v0, d0, e0;
  logic [7:0] h0;

  task automatic push_byte(input logic [7:0] b);
    mem[tail] = b;
    tail = tail + 8'd1;
  endtask

  task automatic snap();
    v0 = n_valid;
    d0 = n_done;
    e0 = n_err;
    h0 = head;
  endtask

  task automatic wait_finish(input string name);
    int k;
    k = 0;
    while (!(pkt_done === 1'b1 || pkt_error === 1'b1) && k < 400) begin
      @(posedge clk);
      #1;
      k++;
    end
    if (k >= 400) begin
      compared++;
      mismatched++;
      $display("FAIL %s_timeout: no packet completion within 400 cycles", name);
    end
    repeat (3) @(negedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    rcving = 1'b0;
    r_error = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    compared++;
    if ({pid, token_addr, token_endp, byte_count, rx_data, rx_data_valid, pkt_done, pkt_error, r_enable} !== '0) begin
      mismatched++;
      $display("FAIL reset_outputs: got pid=%h addr=%h endp=%h cnt=%0d rx=%h v=%b d=%b e=%b ren=%b required all zero",
               pid, token_addr, token_endp, byte_count, rx_data, rx_data_valid, pkt_done, pkt_error, r_enable);
    end
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_data0();
    @(negedge clk);
    snap();
    rcving = 1'b1;
    push_byte(8'hC3); push_byte(8'h11); push_byte(8'h22);
    push_byte(8'h33); push_byte(8'hAA); push_byte(8'hBB);
    rcving = 1'b0;
    wait_finish("data0");
    compared++;
    if (n_valid - v0 !== 3) begin
      mismatched++; $display("FAIL data0_valid_count: got %0d required 3", n_valid - v0);
    end
    compared++;
    if ({rx_log[v0 % 256], rx_log[(v0 + 1) % 256], rx_log[(v0 + 2) % 256]} !== 24'h112233) begin
      mismatched++;
      $display("FAIL data0_payload: got %h %h %h required 11 22 33",
               rx_log[v0 % 256], rx_log[(v0 + 1) % 256], rx_log[(v0 + 2) % 256]);
    end
    compared++;
    if (byte_count !== 7'd3) begin
      mismatched++; $display("FAIL data0_byte_count: got %0d required 3", byte_count);
    end
    compared++;
    if (pid !== 4'h3) begin
      mismatched++; $display("FAIL data0_pid: got %h required 3", pid);
    end
    compared++;
    if (n_done - d0 !== 1 || n_err - e0 !== 0) begin
      mismatched++; $display("FAIL data0_strobes: got done=%0d err=%0d required done=1 err=0", n_done - d0, n_err - e0);
    end
  endtask

  task automatic test_token();
    @(negedge clk);
    snap();
    rcving = 1'b1;
    push_byte(8'h69); push_byte(8'h85); push_byte(8'h01);
    rcving = 1'b0;
    wait_finish("token");
    compared++;
    if (token_addr !== 7'h05) begin
      mismatched++; $display("FAIL token_addr: got %h required 05", token_addr);
    end
    compared++;
    if (token_endp !== 4'h3) begin
      mismatched++; $display("FAIL token_endp: got %h required 3", token_endp);
    end
    compared++;
    if (pid !== 4'h9) begin
      mismatched++; $display("FAIL token_pid: got %h required 9", pid);
    end
    compared++;
    if (n_done - d0 !== 1 || n_err - e0 !== 0 || n_valid - v0 !== 0) begin
      mismatched++;
      $display("FAIL token_strobes: got done=%0d err=%0d valid=%0d required 1 0 0", n_done - d0, n_err - e0, n_valid - v0);
    end
  endtask

  task automatic test_bad_pid();
    @(negedge clk);
    snap();
    rcving = 1'b1;
    push_byte(8'hC4); push_byte(8'h11); push_byte(8'h22);
    rcving = 1'b0;
    wait_finish("bad_pid");
    compared++;
    if (8'(head - h0) !== 8'd3) begin
      mismatched++; $display("FAIL bad_pid_pops: got %0d required 3", 8'(head - h0));
    end
    compared++;
    if (n_err - e0 !== 1 || n_done - d0 !== 0 || n_valid - v0 !== 0) begin
      mismatched++;
      $display("FAIL bad_pid_strobes: got err=%0d done=%0d valid=%0d required 1 0 0", n_err - e0, n_done - d0, n_valid - v0);
    end
  endtask

  task automatic test_handshake();
    @(negedge clk);
    snap();
    rcving = 1'b1;
    push_byte(8'hD2); push_byte(8'h55);
    rcving = 1'b0;
    wait_finish("ack_extra");
    compared++;
    if (n_err - e0 !== 1 || n_done - d0 !== 0) begin
      mismatched++; $display("FAIL ack_extra_strobes: got err=%0d done=%0d required 1 0", n_err - e0, n_done - d0);
    end
    @(negedge clk);
    snap();
    rcving = 1'b1;
    push_byte(8'hD2);
    rcving = 1'b0;
    wait_finish("ack");
    compared++;
    if (pid !== 4'h2) begin
      mismatched++; $display("FAIL ack_pid: got %h required 2", pid);
    end
    compared++;
    if (n_done - d0 !== 1 || n_err - e0 !== 0) begin
      mismatched++; $display("FAIL ack_strobes: got done=%0d err=%0d required 1 0", n_done - d0, n_err - e0);
    end
  endtask

  task automatic test_rx_error();
    int k;
    @(negedge clk);
    snap();
    rcving = 1'b1;
    push_byte(8'h4B); push_byte(8'h01);
    k = 0;
    while (head != tail && k < 50) begin
      @(negedge clk);
      k++;
    end
    if (k >= 50) begin
      compared++; mismatched++;
      $display("FAIL rx_error_drain: FIFO not drained within 50 cycles");
    end
    @(negedge clk);
    r_error = 1'b1;
    @(negedge clk);
    r_error = 1'b0;
    push_byte(8'h02);
    rcving = 1'b0;
    wait_finish("rx_error");
    compared++;
    if (n_err - e0 !== 1 || n_done - d0 !== 0) begin
      mismatched++; $display("FAIL rx_error_strobes: got err=%0d done=%0d required 1 0", n_err - e0, n_done - d0);
    end
    compared++;
    if (8'(head - h0) !== 8'd3 || n_valid - v0 !== 0) begin
      mismatched++; $display("FAIL rx_error_flush: got pops=%0d valid=%0d required 3 0", 8'(head - h0), n_valid - v0);
    end
    compared++;
    if (pid !== 4'hB) begin
      mismatched++; $display("FAIL rx_error_pid: got %h required b", pid);
    end
  endtask

  task automatic test_max_payload();
    @(negedge clk);
    snap();
    rcving = 1'b1;
    push_byte(8'hC3);
    for (int i = 1; i <= 66; i++) push_byte(8'(i));
    rcving = 1'b0;
    wait_finish("max64");
    compared++;
    if (n_done - d0 !== 1 || n_err - e0 !== 0 || byte_count !== 7'd64) begin
      mismatched++;
      $display("FAIL max64_result: got done=%0d err=%0d cnt=%0d required 1 0 64", n_done - d0, n_err - e0, byte_count);
    end
    compared++;
    if (n_valid - v0 !== 64 || rx_log[(v0 + 63) % 256] !== 8'd64) begin
      mismatched++;
      $display("FAIL max64_payload: got valid=%0d last=%0d required 64 64", n_valid - v0, rx_log[(v0 + 63) % 256]);
    end
    @(negedge clk);
    snap();
    rcving = 1'b1;
    push_byte(8'hC3);
    for (int i = 1; i <= 67; i++) push_byte(8'(i));
    rcving = 1'b0;
    wait_finish("over64");
    compared++;
    if (n_err - e0 !== 1 || n_done - d0 !== 0 || n_valid - v0 !== 64) begin
      mismatched++;
      $display("FAIL over64_result: got err=%0d done=%0d valid=%0d required 1 0 64", n_err - e0, n_done - d0, n_valid - v0);
    end
    compared++;
    if (8'(head - h0) !== 8'd68 || byte_count !== 7'd64) begin
      mismatched++; $display("FAIL over64_flush: got pops=%0d cnt=%0d required 68 64", 8'(head - h0), byte_count);
    end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    snap();
    rcving = 1'b1;
    push_byte(8'hC3); push_byte(8'h11); push_byte(8'h22);
    push_byte(8'h33); push_byte(8'h44); push_byte(8'h55);
    repeat (6) @(negedge clk);
    rst = 1'b1;
    #1;
    compared++;
    if ({pid, token_addr, token_endp, byte_count, rx_data, rx_data_valid, pkt_done, pkt_error, r_enable} !== '0) begin
      mismatched++;
      $display("FAIL reset_mid_outputs: got pid=%h addr=%h endp=%h cnt=%0d rx=%h v=%b d=%b e=%b ren=%b required all zero",
               pid, token_addr, token_endp, byte_count, rx_data, rx_data_valid, pkt_done, pkt_error, r_enable);
    end
    tail = head;
    rcving = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    compared++;
    if (n_done - d0 !== 0 || n_err - e0 !== 0) begin
      mismatched++; $display("FAIL reset_mid_strobes: got done=%0d err=%0d required 0 0", n_done - d0, n_err - e0);
    end
    rst = 1'b0;
    @(negedge clk);
    snap();
    rcving = 1'b1;
    push_byte(8'hC3); push_byte(8'hAA); push_byte(8'hBB);
    rcving = 1'b0;
    wait_finish("after_reset");
    compared++;
    if (n_done - d0 !== 1 || n_err - e0 !== 0 || n_valid - v0 !== 0) begin
      mismatched++;
      $display("FAIL after_reset_strobes: got done=%0d err=%0d valid=%0d required 1 0 0", n_done - d0, n_err - e0, n_valid - v0);
    end
    compared++;
    if (byte_count !== 7'd0 || pid !== 4'h3) begin
      mismatched++; $display("FAIL after_reset_fields: got cnt=%0d pid=%h required 0 3", byte_count, pid);
    end
  endtask

  initial begin
    test_reset();
    test_data0();
    test_token();
    test_bad_pid();
    test_handshake();
    test_rx_error();
    test_max_payload();
    test_reset_mid();
    compared++;
    if (n_overlap !== 0) begin
      mismatched++; $display("FAIL strobe_exclusive: got %0d overlapping cycles required 0", n_overlap);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
